// File: rtl/seg7_pkg.sv
// Shared types, segment encodings and helpers for the seven-segment display path.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package seg7_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } cvt_state_t;

    // Active-low cathodes, seg[6]=CA .. seg[0]=CG.
    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_LUT [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    function automatic seg_t bcd_to_seg(bcd_t b);
        if (b <= 4'd9) begin
            return SEG_LUT[int'(b)];
        end
        return SEG_BLANK;
    endfunction

    function automatic longint unsigned pow10(int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with range flag captured at load.
// Latency: busy rises on the load edge and falls VALUE_W+1 edges later; done pulses in the final busy cycle.
// Backpressure: load is ignored while busy; there is no queueing.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int VALUE_W    = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [VALUE_W-1:0]      value,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
    localparam longint unsigned MAX_VAL = pow10(NUM_DIGITS) - 1;

    cvt_state_t         state_q;
    logic [VALUE_W-1:0] bin_q;
    logic [CW-1:0]      step_q;
    logic [BW-1:0]      bcd_adj;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            bin_q   <= '0;
            bcd     <= '0;
            step_q  <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        bin_q   <= value;
                        bcd     <= '0;
                        step_q  <= '0;
                        ovf     <= 64'(value) > MAX_VAL;
                        busy    <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {bcd, bin_q} <= {bcd_adj, bin_q} << 1;
                    step_q       <= step_q + 1'b1;
                    if (step_q == CW'(VALUE_W - 1)) begin
                        state_q <= ST_DONE;
                        done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multi-digit seven-segment driver: binary load -> BCD -> time-multiplexed active-low seg/an.
// Latency: display updates as busy falls; seg/an follow one edge later. SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Backpressure: load ignored while busy; the scanner free-runs and never stalls.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14,
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  load,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  dp
);

    localparam int TICK_DIV = CLK_HZ / REFRESH_HZ;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    generate
        if (TICK_DIV < 1) begin : g_bad_tick_div
            $error("seg7_scan_driver: CLK_HZ/REFRESH_HZ must be at least 1");
        end
    endgenerate

    logic                    cvt_done;
    logic                    cvt_ovf;
    logic [4*NUM_DIGITS-1:0] cvt_bcd;
    bcd_t                    digit_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   blank_q;
    logic [NUM_DIGITS-1:0]   blank_nxt;
    logic [PW-1:0]           presc_q;
    logic [IW-1:0]           idx_q;

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_cvt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .value (value),
        .busy  (busy),
        .done  (cvt_done),
        .ovf   (cvt_ovf),
        .bcd   (cvt_bcd)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic seen_nz;
    always_comb begin
        blank_nxt = '0;
        seen_nz   = 1'b0;
        // Digit 0 always stays lit so a zero value still shows a single "0".
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            seen_nz      = seen_nz | (cvt_bcd[4*i +: 4] != 4'd0);
            blank_nxt[i] = ~seen_nz;
        end
    end
`else
    always_comb begin
        blank_nxt = '0;
    end
`endif

    // Digits, blank mask and overflow change together on the done cycle so the scan never tears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= '0;
            end
            blank_q  <= '0;
            overflow <= 1'b0;
        end else if (cvt_done) begin
            overflow <= cvt_ovf;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= cvt_ovf ? 4'd9 : cvt_bcd[4*i +: 4];
            end
            blank_q <= cvt_ovf ? '0 : blank_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            an      <= ~(NUM_DIGITS'(1));
            seg     <= SEG_LUT[0];
        end else begin
            if (presc_q == PW'(TICK_DIV - 1)) begin
                presc_q <= '0;
                idx_q   <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
            an  <= ~(NUM_DIGITS'(1) << idx_q);
            seg <= blank_q[idx_q] ? SEG_BLANK : bcd_to_seg(digit_q[idx_q]);
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed table, hand-written corner sequences, random loads.
// Honours SEG7_LEADING_ZERO_BLANK_EN when computing expected segment patterns.
module tb_seg7_scan_driver;

    localparam int          VW      = 14;
    localparam int          LAT     = VW + 2;
    localparam logic [6:0]  SB      = 7'b1111111;
    localparam logic [6:0]  S0      = 7'b0000001;
    localparam logic [6:0]  S9      = 7'b0000100;
    localparam logic [6:0]  LUT [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    typedef struct {
        int          value;
        logic        ovf;
        logic [27:0] segs;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [VW-1:0] value;
    logic          busy;
    logic          overflow;
    logic [6:0]    seg;
    logic [3:0]    an;
    logic          dp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS (4),
        .VALUE_W    (VW),
        .CLK_HZ     (1000),
        .REFRESH_HZ (250)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value    (value),
        .load     (load),
        .busy     (busy),
        .overflow (overflow),
        .seg      (seg),
        .an       (an),
        .dp       (dp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Expected display straight from decimal arithmetic on the loaded value.
    function automatic logic [27:0] model(int v);
        logic [27:0] r;
        int          p;
        int          msd;
        if (v > 9999) return {4{S9}};
        msd = 0;
        p   = 1;
        for (int i = 0; i < 4; i++) begin
            if ((v / p) % 10 != 0) msd = i;
            r[7*i +: 7] = LUT[(v / p) % 10];
            p = p * 10;
        end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        for (int i = 1; i < 4; i++) begin
            if (i > msd) r[7*i +: 7] = SB;
        end
`endif
        return r;
    endfunction

    // Pulses load and returns edges from the load edge until busy is seen low.
    task automatic convert(input int v, input logic prev_ovf, output int edges);
        value = VW'(v);
        load  = 1'b1;
        tick();
        load  = 1'b0;
        edges = 1;
        chk("busy_rise", busy, 1'b1);
        chk("ovf_hold", overflow, prev_ovf);
        while (busy === 1'b1 && edges < 100) begin
            tick();
            edges++;
        end
    endtask

    task automatic read_display(output logic [27:0] d);
        logic found;
        d = 'x;
        for (int c = 0; c < 16; c++) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (an === ~(4'b0001 << k)) begin
                    d[7*k +: 7] = seg;
                    found = 1'b1;
                end
            end
            chk("an_onehot", found, 1'b1);
            chk("dp_off", dp, 1'b1);
            tick();
        end
    endtask

    task automatic check_display(input string tag, input logic [27:0] exp);
        logic [27:0] d;
        tick();
        read_display(d);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_digit%0d", tag, k), d[7*k +: 7], exp[7*k +: 7]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [6];
        logic [3:0]  scan_seq [0:4];
        logic        cur_ovf;
        int          edges;
        int          v;

        tbl[0] = '{1234, 1'b0, {LUT[1], LUT[2], LUT[3], LUT[4]}};
        tbl[1] = '{10000, 1'b1, {S9, S9, S9, S9}};
        tbl[4] = '{9999, 1'b0, {S9, S9, S9, S9}};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        tbl[2] = '{42, 1'b0, {SB, SB, LUT[4], LUT[2]}};
        tbl[3] = '{0, 1'b0, {SB, SB, SB, S0}};
        tbl[5] = '{7, 1'b0, {SB, SB, SB, LUT[7]}};
`else
        tbl[2] = '{42, 1'b0, {S0, S0, LUT[4], LUT[2]}};
        tbl[3] = '{0, 1'b0, {S0, S0, S0, S0}};
        tbl[5] = '{7, 1'b0, {S0, S0, S0, LUT[7]}};
`endif
        scan_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};

        rst_n = 1'b0;
        load  = 1'b0;
        value = '0;
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_an", an, 4'b1110);
        chk("rst_seg", seg, S0);
        chk("rst_dp", dp, 1'b1);

        // Scan order and four-cycle dwell.
        rst_n = 1'b1;
        for (int c = 0; c < 10 && an !== 4'b1101; c++) tick();
        chk("scan_start", an, 4'b1101);
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("scan_an_%0d_%0d", s, c), an, scan_seq[s]);
                tick();
            end
        end

        cur_ovf = 1'b0;
        for (int t = 0; t < 6; t++) begin
            convert(tbl[t].value, cur_ovf, edges);
            chk($sformatf("tbl%0d_latency", t), edges, LAT);
            chk($sformatf("tbl%0d_overflow", t), overflow, tbl[t].ovf);
            cur_ovf = tbl[t].ovf;
            check_display($sformatf("tbl%0d", t), tbl[t].segs);
        end

        // Second load three cycles into a conversion must be dropped.
        value = VW'(5678);
        load  = 1'b1;
        tick();
        load  = 1'b0;
        tick();
        tick();
        value = VW'(1111);
        load  = 1'b1;
        tick();
        load  = 1'b0;
        edges = 4;
        chk("ign_busy", busy, 1'b1);
        while (busy === 1'b1 && edges < 100) begin
            tick();
            edges++;
        end
        chk("ign_latency", edges, LAT);
        tick();
        chk("ign_busy_stays_low", busy, 1'b0);
        check_display("ign", model(5678));

        // Reset in the middle of a conversion aborts it and clears the display.
        value = VW'(9999);
        load  = 1'b1;
        tick();
        load  = 1'b0;
        repeat (5) tick();
        chk("abort_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("abort_busy", busy, 1'b0);
        chk("abort_an", an, 4'b1110);
        chk("abort_seg", seg, S0);
        chk("abort_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        check_display("abort", {S0, S0, S0, S0});
        chk("abort_busy_after", busy, 1'b0);

        cur_ovf = 1'b0;
        for (int r = 0; r < 24; r++) begin
            v = (r % 6 == 0) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 16383));
            convert(v, cur_ovf, edges);
            chk($sformatf("rnd%0d_latency", r), edges, LAT);
            chk($sformatf("rnd%0d_overflow", r), overflow, v > 9999);
            cur_ovf = (v > 9999);
            check_display($sformatf("rnd%0d_v%0d", r, v), model(v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
